axis_packet_source: RTL
=======================

# axis_packet_source

AXI-Stream master that generates finite test packets (incrementing or LFSR payload) and drives the `s01_axis_*` slave port of `memory_controller`. It is the transmit end of the stream interface that `memory_controller` receives on. It sits between a control/CSR layer (`start`, length, seed) and the memory controller, and honours backpressure on `tready` with no bubbles.

## Interface
- `DATA_WIDTH`, 32: width of `m01_axis_tdata`; `tstrb` is `DATA_WIDTH/8` bits.
- `LEN_WIDTH`, 12: width of `pkt_len`. The maximum packet length is 2^LEN_WIDTH beats, which matches `MEM_SIZE` 4096.
- `LFSR_POLY`, 32'h80200003: Galois feedback mask, `DATA_WIDTH` bits wide.

Ports:
- `m01_axis_aclk` in 1: the single clock; all logic is rising-edge.
- `m01_axis_areset` in 1: reset, asynchronous and active-high.
- `start` in 1: request one packet; sampled only in IDLE.
- `pkt_len` in LEN_WIDTH: beats minus 1; captured on an accepted `start`.
- `mode` in 1: 0 = incrementing payload, 1 = LFSR payload; captured on `start`.
- `seed` in DATA_WIDTH: first payload word; captured on `start`.
- `abort` in 1: request early termination of the current packet.
- `busy` out 1: high from the cycle after `start` until the final handshake.
- `done` out 1: one-cycle pulse after the final beat is accepted.
- `aborted` out 1: sticky flag meaning the last packet was shortened; cleared on the next accepted `start`.
- `m01_axis_tdata` out DATA_WIDTH: payload.
- `m01_axis_tstrb` out DATA_WIDTH/8: all ones while `tvalid`, otherwise 0.
- `m01_axis_tvalid` out 1: beat valid.
- `m01_axis_tlast` out 1: final beat of the packet.
- `m01_axis_tready` in 1: downstream accept.

## Operation
- FSM states: IDLE, SEND, DONE.
- **IDLE → SEND** when `start`=1. Capture `len` = `pkt_len`, `mode`, and `seed`. Set beat index k=0 and clear `aborted`.
- **SEND.** Present beat k. On a handshake (`tvalid && tready`):
  - if `tlast`=1, go to DONE;
  - otherwise k+1 and the next payload word are presented on the following cycle.
- **DONE → IDLE** unconditionally. `done`=1 in DONE only.
- **Payload, incrementing:** word k = `seed` + k, modulo 2^DATA_WIDTH (wraps silently).
- **Payload, LFSR:** word 0 = `seed`, but a seed of 0 is replaced by 1. Each subsequent word = (x >> 1) ^ (x[0] ? LFSR_POLY : 0).
- **tlast** = (k == `len`) or `abort_pend`.
- **Beat count:** a packet is `len`+1 beats. `pkt_len`=0 gives 1 beat; all-ones gives 4096 beats with no counter overflow.
- **AXIS stability:** while `tvalid`=1 and `tready`=0, `tdata`, `tstrb` and `tlast` are held stable. `tvalid` never drops before a handshake.
- **Abort:**
  - When `abort`=1 in SEND, set `abort_pend`.
  - The beat currently presented is unchanged. The next beat presented after its handshake carries `tlast`=1 and ends the packet; `aborted` is then set.
  - If the presented beat is already the last one, `abort` has no effect and `aborted` stays 0.
  - `abort` in IDLE or DONE is ignored.
- `start` during SEND or DONE is ignored; it is not queued.
- Reset mid-packet: all state returns to the reset values immediately; the partial packet is dropped and no `tlast` is issued.

## Timing
- Reset values: `tvalid`, `tlast`, `tstrb`, `busy`, `done`, `aborted` = 0; `tdata` = 0; state = IDLE.
- Start latency: `start` at cycle N puts the first beat on the outputs at N+1 (registered outputs).
- Throughput: one beat per cycle while `tready`=1; no idle cycle between beats.
- End of packet: a final handshake at cycle M gives `tvalid`=0 and `done`=1 at M+1, and IDLE at M+2. The earliest next `start` is accepted at M+2.
- All outputs are registered. `tready` is used only combinationally into next-state logic and never reaches an output in the same cycle.

## Structure
- Shared package `axis_src_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_SEND`, `ST_DONE`);
  - mode constants `MODE_INC`=0 and `MODE_LFSR`=1;
  - the default polynomial `LFSR_POLY_32`.
- One sub-module, `axis_pattern_gen`: combinational next-word function (current word, mode, poly → next word), reused by the checker in the bench.

## Test plan
- **Incrementing packet:** `seed`=0x55, `pkt_len`=2, `mode`=0, `tready`=1 → beats 0x55, 0x56, 0x57 on consecutive cycles; `tlast` only on 0x57; `done` one cycle later.
- **LFSR packet:** `seed`=1, `pkt_len`=3, `mode`=1 → beats 0x00000001, 0x80200003, 0xC0300002, 0x60180001; `tlast` on the 4th beat.
- **Backpressure:** `seed`=0x22, `pkt_len`=1, `tready` held 0 for 5 cycles and then 1 → 0x22 is stable for all 6 cycles, then 0x23 with `tlast`; no beat is lost or duplicated.
- **Abort:** `pkt_len`=9, `abort` pulsed while beat 2 is presented and stalled → beat 2 is unchanged, beat 3 carries `tlast`, 4 beats total, `aborted`=1, `done` pulses.
- **Wrap and maximum length:** `seed`=0xFFFFFFFE, `pkt_len`=0xFFF → 4096 beats; word 2 = 0x00000000; `tlast` only on beat 4095.
- **Reset mid-packet:** reset asserted during beat 3 of 8 → `tvalid`=0 asynchronously and all status outputs 0. A fresh `start` after release sends a full 8-beat packet from `seed`.

Source files
------------

// File: rtl/axis_src_pkg.sv
// Shared definitions for the AXI-Stream packet source.
//   state_e       : packet FSM states
//   MODE_INC/LFSR : payload mode encodings on the `mode` input
//   LFSR_POLY_32  : default Galois feedback mask for 32-bit payloads
package axis_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic        MODE_INC     = 1'b0;
  localparam logic        MODE_LFSR    = 1'b1;
  localparam logic [31:0] LFSR_POLY_32 = 32'h80200003;

endpackage

// File: rtl/axis_pattern_gen.sv
// Combinational next-payload-word function.
//   cur_word  in  : word currently presented
//   mode      in  : MODE_INC -> cur+1 (wraps), MODE_LFSR -> Galois LFSR step
//   poly      in  : LFSR feedback mask
//   next_word out : word for the following beat
module axis_pattern_gen
  import axis_src_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] cur_word,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] poly,
  output logic [DATA_WIDTH-1:0] next_word
);

  always_comb begin
    next_word = cur_word + DATA_WIDTH'(1);
    if (mode == MODE_LFSR)
      next_word = (cur_word >> 1) ^ (cur_word[0] ? poly : '0);
  end

endmodule

// File: rtl/axis_packet_source.sv
// AXI-Stream master emitting one finite test packet per accepted `start`.
// Ports:
//   m01_axis_aclk / m01_axis_areset : clock, async active-high reset
//   start, pkt_len, mode, seed      : packet request (captured in IDLE)
//   abort                           : shorten the current packet
//   busy, done, aborted             : status (all registered)
//   m01_axis_t*                     : AXI-Stream master port
// All outputs are flops; tready only feeds next-state logic.
module axis_packet_source
  import axis_src_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LEN_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(LFSR_POLY_32)
) (
  input  logic                    m01_axis_aclk,
  input  logic                    m01_axis_areset,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  input  logic                    mode,
  input  logic [DATA_WIDTH-1:0]   seed,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   k_q, k_d;
  logic                   mode_q, mode_d;
  logic                   abort_pend_q, abort_pend_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [STRB_W-1:0]      tstrb_q, tstrb_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;

  logic [DATA_WIDTH-1:0]  next_word;
  logic [DATA_WIDTH-1:0]  first_word;
  logic [LEN_WIDTH-1:0]   k_inc;
  logic                   hs;
  logic                   pend_nxt;

  axis_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_gen (
    .cur_word  (tdata_q),
    .mode      (mode_q),
    .poly      (LFSR_POLY),
    .next_word (next_word)
  );

  assign hs    = tvalid_q & m01_axis_tready;
  assign k_inc = k_q + LEN_WIDTH'(1);
  // An all-zero LFSR state would lock up, so seed 0 becomes 1 in LFSR mode.
  assign first_word = (mode == MODE_LFSR && seed == '0) ? DATA_WIDTH'(1) : seed;
  // Abort on the beat that is already last has nothing left to shorten.
  assign pend_nxt = abort_pend_q | (abort & ~tlast_q);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    k_d          = k_q;
    mode_d       = mode_q;
    abort_pend_d = abort_pend_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SEND;
          len_d        = pkt_len;
          mode_d       = mode;
          k_d          = '0;
          abort_pend_d = 1'b0;
          aborted_d    = 1'b0;
          tdata_d      = first_word;
          tvalid_d     = 1'b1;
          tlast_d      = (pkt_len == '0);
          busy_d       = 1'b1;
        end
      end
      ST_SEND: begin
        abort_pend_d = pend_nxt;
        if (hs) begin
          if (tlast_q) begin
            state_d   = ST_DONE;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = abort_pend_q;
          end else begin
            k_d     = k_inc;
            tdata_d = next_word;
            tlast_d = (k_inc == len_q) | pend_nxt;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    tstrb_d = {STRB_W{tvalid_d}};
  end

  always_ff @(posedge m01_axis_aclk or posedge m01_axis_areset) begin
    if (m01_axis_areset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      k_q          <= '0;
      mode_q       <= MODE_INC;
      abort_pend_q <= 1'b0;
      tdata_q      <= '0;
      tstrb_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      k_q          <= k_d;
      mode_q       <= mode_d;
      abort_pend_q <= abort_pend_d;
      tdata_q      <= tdata_d;
      tstrb_q      <= tstrb_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign m01_axis_tdata  = tdata_q;
  assign m01_axis_tstrb  = tstrb_q;
  assign m01_axis_tvalid = tvalid_q;
  assign m01_axis_tlast  = tlast_q;

endmodule
